// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-flop synchroniser per channel, shared tick prescaler,
// per-channel stability counter producing a clean level plus rise/fall pulses.
module key_debounce_multi #(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned TICK_DIV   = 500000,
   parameter int unsigned STABLE_CNT = 4,
   parameter logic        RST_LEVEL  = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] key_raw,
   output logic [N_CH-1:0] key_level,
   output logic [N_CH-1:0] key_rise,
   output logic [N_CH-1:0] key_fall,
   output logic            tick
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] CNT_LAST = SW'(STABLE_CNT - 1);

   logic [PW-1:0]            div_q, div_d;
   logic                     tick_q, tick_d;
   logic [N_CH-1:0]          s1_q, s2_q;
   logic [N_CH-1:0]          level_q, level_d;
   logic [N_CH-1:0]          rise_q, rise_d;
   logic [N_CH-1:0]          fall_q, fall_d;
   logic [N_CH-1:0][SW-1:0]  cnt_q, cnt_d;

   // State registers; reset clears everything including partial counts
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q   <= '0;
         tick_q  <= 1'b0;
         s1_q    <= {N_CH{RST_LEVEL}};
         s2_q    <= {N_CH{RST_LEVEL}};
         level_q <= {N_CH{RST_LEVEL}};
         rise_q  <= '0;
         fall_q  <= '0;
         cnt_q   <= '0;
      end else begin
         div_q   <= div_d;
         tick_q  <= tick_d;
         s1_q    <= key_raw;
         s2_q    <= s1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
      end
   end

   // Prescaler: tick is registered one cycle after the count reaches its last value
   always_comb begin
      div_d  = div_q + PW'(1);
      tick_d = 1'b0;
      if (div_q == DIV_LAST) begin
         div_d  = '0;
         tick_d = 1'b1;
      end
   end

   // Per-channel stability counters, advanced only on ticks
   always_comb begin
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      cnt_d   = cnt_q;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (tick_q) begin
            if (s2_q[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               level_d[i] = s2_q[i];
               cnt_d[i]   = '0;
               rise_d[i]  = s2_q[i];
               fall_d[i]  = ~s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + SW'(1);
            end
         end
      end
   end

   assign key_level = level_q;
   assign key_rise  = rise_q;
   assign key_fall  = fall_q;
   assign tick      = tick_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: per-cycle vector table on a TICK_DIV=1 instance,
// hand-written prescaler/latency/glitch sequences on a TICK_DIV=5 instance.
module tb_key_debounce_multi;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [3:0] raw_a, raw_b;
   logic [3:0] lvl_a, rise_a, fall_a, lvl_b, rise_b, fall_b;
   logic       tick_a, tick_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   key_debounce_multi #(.N_CH(4), .TICK_DIV(1), .STABLE_CNT(4), .RST_LEVEL(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_a), .key_raw(raw_a),
      .key_level(lvl_a), .key_rise(rise_a), .key_fall(fall_a), .tick(tick_a));

   key_debounce_multi #(.N_CH(4), .TICK_DIV(5), .STABLE_CNT(2), .RST_LEVEL(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_b), .key_raw(raw_b),
      .key_level(lvl_b), .key_rise(rise_b), .key_fall(fall_b), .tick(tick_b));

   typedef struct {
      logic       rst_n;
      logic [3:0] raw;
      logic [3:0] lvl;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       tick;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [3:0] raw, input logic [3:0] lv,
                      input logic [3:0] ri, input logic [3:0] fa, input logic tk,
                      input int reps = 1);
      vec_t v;
      v.rst_n = r; v.raw = raw; v.lvl = lv; v.rise = ri; v.fall = fa; v.tick = tk;
      for (int k = 0; k < reps; k++) vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   int lat, rises, falls;
   bit got;

   initial begin
      rst_a = 1'b0; raw_a = 4'hF;
      rst_b = 1'b0; raw_b = 4'h0;

      // Vectors: inputs applied before an edge, outputs expected just after it
      add(0, 4'hF, 4'h0, 4'h0, 4'h0, 0, 3);   // reset held with keys pressed
      add(1, 4'h1, 4'h0, 4'h0, 4'h0, 1, 5);   // clean press ch0
      add(1, 4'h1, 4'h1, 4'h1, 4'h0, 1);
      add(1, 4'h1, 4'h1, 4'h0, 4'h0, 1);
      add(1, 4'h3, 4'h1, 4'h0, 4'h0, 1);      // ch1 bounces 1,0,1,0
      add(1, 4'h1, 4'h1, 4'h0, 4'h0, 1);
      add(1, 4'h3, 4'h1, 4'h0, 4'h0, 1);
      add(1, 4'h1, 4'h1, 4'h0, 4'h0, 1);
      add(1, 4'h3, 4'h1, 4'h0, 4'h0, 1, 5);   // then settles high
      add(1, 4'h3, 4'h3, 4'h2, 4'h0, 1);
      add(1, 4'h3, 4'h3, 4'h0, 4'h0, 1);
      add(1, 4'hF, 4'h3, 4'h0, 4'h0, 1, 5);   // bring ch2/ch3 up
      add(1, 4'hF, 4'hF, 4'hC, 4'h0, 1);
      add(1, 4'hF, 4'hF, 4'h0, 4'h0, 1);
      add(1, 4'h0, 4'hF, 4'h0, 4'h0, 1, 5);   // release all at once
      add(1, 4'h0, 4'h0, 4'h0, 4'hF, 1);
      add(1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
      add(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 4);   // press all, count reaches 2
      add(0, 4'hF, 4'h0, 4'h0, 4'h0, 0);      // one-cycle reset mid-count
      add(1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 5);   // count restarts from zero
      add(1, 4'hF, 4'hF, 4'hF, 4'h0, 1);
      add(1, 4'hF, 4'hF, 4'h0, 4'h0, 1);

      foreach (vecs[i]) begin
         rst_a = vecs[i].rst_n;
         raw_a = vecs[i].raw;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), 16'({lvl_a, rise_a, fall_a, tick_a}),
               16'({vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].tick}));
      end

      // Prescaler instance: reset, then tick every fifth cycle
      rst_b = 1'b0; raw_b = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      check("b_reset", 16'({lvl_b, rise_b, fall_b, tick_b}), 16'h0);
      rst_b = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         check($sformatf("b_tick%0d", n), 16'(tick_b), 16'((n % 5) == 0));
      end

      // Press ch0: ticks land at the 6th and 11th edge, so level rises at edge 11
      raw_b = 4'h1;
      got = 1'b0; lat = 0; rises = 0; falls = 0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (!got && lvl_b[0]) begin
            got = 1'b1;
            lat = n;
         end
         rises += int'(rise_b[0]);
         falls += int'(fall_b[0]);
      end
      check("b_press_seen", 16'(got), 16'h1);
      check("b_press_latency", 16'(lat), 16'd11);
      check("b_press_rises", 16'(rises), 16'd1);
      check("b_press_falls", 16'(falls), 16'd0);
      check("b_other_ch", 16'(lvl_b[3:1]), 16'h0);

      // Three-cycle low glitch spans at most one tick and must be ignored
      raw_b = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      raw_b = 4'h1;
      falls = 0;
      for (int n = 1; n <= 15; n++) begin
         @(posedge clk); #1;
         falls += int'(fall_b[0]);
      end
      check("b_glitch_falls", 16'(falls), 16'd0);
      check("b_glitch_level", 16'(lvl_b), 16'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
